// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle AND/OR/XOR/NOR unit, SLICE bits per cycle, start/busy/done handshake.
// Optional zero flag output enabled by defining LOGIC_ZERO_FLAG_EN.
`default_nettype none

module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
`ifdef LOGIC_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [1:0]       op_lat;
    logic             accept;
    logic             last_slice;
    logic [SLICE-1:0] a_cur;
    logic [SLICE-1:0] b_cur;
    logic [SLICE-1:0] f_cur;
    logic [WIDTH-1:0] res_next;

    // A request is taken in IDLE and also in DONE, so back-to-back ops lose no cycle.
    assign accept     = start && (state != S_RUN);
    assign last_slice = (state == S_RUN) && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == LAST_CNT) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = start ? S_RUN : S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < NS; i++) begin
            if (cnt == CW'(i)) begin
                a_cur = a_lat[i*SLICE +: SLICE];
                b_cur = b_lat[i*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        case (op_lat)
            OP_AND:  f_cur = a_cur & b_cur;
            OP_OR:   f_cur = a_cur | b_cur;
            OP_XOR:  f_cur = a_cur ^ b_cur;
            default: f_cur = ~(a_cur | b_cur);
        endcase
    end

    always_comb begin
        res_next = res;
        for (int i = 0; i < NS; i++) begin
            if (cnt == CW'(i)) begin
                res_next[i*SLICE +: SLICE] = f_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            a_lat  <= '0;
            b_lat  <= '0;
            op_lat <= '0;
            res    <= '0;
        end else if (accept) begin
            cnt    <= '0;
            a_lat  <= a;
            b_lat  <= b;
            op_lat <= op;
            res    <= '0;
        end else if (state == S_RUN) begin
            res <= res_next;
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
        end
    end

`ifdef LOGIC_ZERO_FLAG_EN
    // Judged on the final result, which includes the slice written on this same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero <= 1'b0;
        end else if (last_slice) begin
            zero <= (res_next == '0);
        end
    end
`else
    // Without the zero flag the final-slice strobe has no consumer.
    logic unused_last_slice;
    assign unused_last_slice = last_slice;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq: one 32/8 instance and one 32/32 instance.
`default_nettype none

module tb_logic_unit_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start2;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic        busy2;
    logic        done2;
    logic [31:0] res2;
`ifdef LOGIC_ZERO_FLAG_EN
    logic        zero;
    logic        zero2;
`endif

    typedef struct packed {
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .res(res)
`ifdef LOGIC_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(32)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .op(op), .a(a), .b(b),
        .busy(busy2), .done(done2), .res(res2)
`ifdef LOGIC_ZERO_FLAG_EN
        , .zero(zero2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", done, 0);
            end else begin
                e = q1.pop_front();
                chk("dut1_res", res, e.r);
`ifdef LOGIC_ZERO_FLAG_EN
                chk("dut1_zero", zero, e.z);
`endif
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_done", done2, 0);
            end else begin
                e = q2.pop_front();
                chk("dut2_res", res2, e.r);
`ifdef LOGIC_ZERO_FLAG_EN
                chk("dut2_zero", zero2, e.z);
`endif
            end
        end
    end

    // One complete operation on the selected instance, with handshake timing checks.
    task automatic run(input int which, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] er, input logic ez, input int ns);
        int cyc;
        int bcnt;
        @(negedge clk);
        op = o;
        a  = x;
        b  = y;
        if (which == 1) begin
            start = 1'b1;
            q1.push_back('{r: er, z: ez});
        end else begin
            start2 = 1'b1;
            q2.push_back('{r: er, z: ez});
        end
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom);
        chk("res_cleared_on_accept", (which == 1) ? res : res2, 0);
        cyc  = 1;
        bcnt = 0;
        while (!((which == 1) ? done : done2) && cyc < 20) begin
            if ((which == 1) ? busy : busy2) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk("accept_to_done_latency", cyc, ns + 1);
        chk("busy_cycles", bcnt, ns);
        @(negedge clk);
        chk("done_single_pulse", (which == 1) ? done : done2, 0);
        chk("res_hold_after_done", (which == 1) ? res : res2, er);
    endtask

    initial begin
        int cyc;
        int dcnt;
        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_res", res, 0);
        chk("reset_res2", res2, 0);
`ifdef LOGIC_ZERO_FLAG_EN
        chk("reset_zero", zero, 0);
`endif
        reset = 1'b0;

        run(1, 2'b00, 32'hF0F0_1234, 32'hFF00_FFFF, 32'hF000_1234, 1'b0, 4);
        run(1, 2'b11, 32'h0000_0000, 32'h0000_00FF, 32'hFFFF_FF00, 1'b0, 4);
        run(1, 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 4);

        // start held through RUN is ignored; start seen in DONE starts the next op
        @(negedge clk);
        op    = 2'b01;
        a     = 32'h1234_5678;
        b     = 32'h0000_0000;
        start = 1'b1;
        q1.push_back('{r: 32'h1234_5678, z: 1'b0});
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                op = 2'b10;
                a  = 32'hAAAA_5555;
                b  = 32'hFFFF_0000;
            end
        end while (!done && cyc < 20);
        chk("held_start_latency", cyc, 5);
        q1.push_back('{r: 32'h5555_5555, z: 1'b0});
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
        end while (!done && cyc < 20);
        chk("done_to_done_edges", cyc, 5);

        // reset in the second RUN cycle aborts with no done pulse
        @(negedge clk);
        op    = 2'b01;
        a     = 32'h0F0F_0F0F;
        b     = 32'hF0F0_F0F0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_before_reset", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_res", res, 0);
        chk("abort_done", done, 0);
`ifdef LOGIC_ZERO_FLAG_EN
        chk("abort_zero", zero, 0);
`endif
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);

        // single-slice instance
        run(2, 2'b01, 32'h8000_0001, 32'h0000_0010, 32'h8000_0011, 1'b0, 1);
        run(2, 2'b00, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1);

        repeat (3) @(negedge clk);
        chk("dut1_all_results_seen", q1.size(), 0);
        chk("dut2_all_results_seen", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
